pwm_ramp_ctrl: RTL and testbench

Duty-cycle controller that sits in front of the PWM generator and owns its duty setpoint. It arbitrates between two requesters: debounced push-button step events and a host command port with valid/ready handshake. It ramps the applied duty toward the requested target one step at a time. Every duty change is aligned to a PWM period boundary, so the PWM output never sees a mid-period glitch.

---
 rtl/pwm_pkg.sv | 51 +++++
 rtl/pwm_step_timer.sv | 47 ++++
 rtl/pwm_ramp_ctrl.sv | 135 +++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_pkg                                                    |
// | Description : Shared PWM definitions: default period/duty width used by |
// |               both the PWM generator and the duty controller, the ramp  |
// |               state type, and duty arithmetic helpers (clamp, saturating|
// |               button step, one-step-toward-target).                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_PERIOD = 10;
  localparam int PWM_DUTY_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Limit a requested duty to the PWM period.
  function automatic logic [31:0] clamp_duty(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

  // Saturating +1 / -1 used by the push-button path; never wraps.
  function automatic logic [31:0] sat_step(input logic [31:0] val,
                                           input logic        up,
                                           input logic [31:0] max_val);
    logic [31:0] res;
    res = val;
    if (up) begin
      if (val < max_val) res = val + 32'd1;
    end else begin
      if (val != 32'd0) res = val - 32'd1;
    end
    return res;
  endfunction

  // Move one count from cur toward tgt (no move when equal).
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt);
    logic [31:0] res;
    res = cur;
    if (cur < tgt)      res = cur + 32'd1;
    else if (cur > tgt) res = cur - 32'd1;
    return res;
  endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_step_timer                                             |
// | Description : Divides PWM period wraps by RAMP_DIV and emits a one-cycle |
// |               combinational step strobe on the wrap that completes a    |
// |               ramp interval. Only built with PWM_RAMP_CTRL_SOFT_EN.     |
// | Ports       : clk, rst_n   - clock, async active-low reset               |
// |               clear        - hold the divider at zero                    |
// |               cnt_en       - allow period_wrap to be counted             |
// |               period_wrap  - PWM counter wrap pulse                      |
// |               step         - ramp step strobe                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`ifdef PWM_RAMP_CTRL_SOFT_EN
module pwm_step_timer #(
  parameter int RAMP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  input  logic period_wrap,
  output logic step
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] wrap_cnt;
  logic             last_wrap;

  assign last_wrap = (wrap_cnt == CNT_LAST);
  assign step      = ~clear & cnt_en & period_wrap & last_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt <= '0;
    end else if (clear) begin
      wrap_cnt <= '0;
    end else if (cnt_en && period_wrap) begin
      wrap_cnt <= last_wrap ? '0 : wrap_cnt + 1'b1;
    end
  end

endmodule : pwm_step_timer
`endif
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_ramp_ctrl                                              |
// | Description : Owns the PWM duty setpoint. Arbitrates host commands       |
// |               (valid/ready) and debounced +/- buttons into a target,    |
// |               then moves the applied duty toward it only on PWM period  |
// |               boundaries.                                               |
// | Macro       : PWM_RAMP_CTRL_SOFT_EN - defined: one step every RAMP_DIV  |
// |               periods; undefined: jump to target on the first wrap.     |
// | Ports       : clk, rst_n   - clock, async active-low reset               |
// |               ena          - block enable (low freezes all state)        |
// |               period_wrap  - PWM counter wrap pulse                      |
// |               inc_pulse, dec_pulse - button events                       |
// |               cmd_valid, cmd_duty, cmd_ready - host command port         |
// |               duty, duty_upd - applied duty and its update strobe        |
// |               busy         - duty differs from target                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int PERIOD    = PWM_PERIOD,
  parameter int DUTY_W    = PWM_DUTY_W,
  parameter int RAMP_DIV  = 4,
  parameter int DUTY_INIT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              period_wrap,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              cmd_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              busy
);

  if ((2 ** DUTY_W) <= PERIOD || RAMP_DIV < 1 || DUTY_INIT > PERIOD) begin : g_param_check
    $error("pwm_ramp_ctrl: illegal PERIOD/DUTY_W/RAMP_DIV/DUTY_INIT combination");
  end

  ramp_state_t       state;
  logic [DUTY_W-1:0] target;

  logic              ramp_active;
  logic              accept;
  logic              btn_inc;
  logic              btn_dec;
  logic              step;
  logic [DUTY_W-1:0] cmd_target;
  logic [DUTY_W-1:0] btn_target;
  logic [DUTY_W-1:0] step_duty;
  logic [DUTY_W-1:0] next_duty;

  assign ramp_active = (state == RAMP);
  assign busy        = ramp_active;
  // Gated with rst_n so the host sees "not ready" for the whole reset.
  assign cmd_ready   = rst_n & ena & ~ramp_active;
  assign accept      = cmd_valid & cmd_ready;

  // Simultaneous +/- cancel; a host acceptance drops buttons in that cycle.
  assign btn_inc = ena & inc_pulse & ~dec_pulse & ~accept;
  assign btn_dec = ena & dec_pulse & ~inc_pulse & ~accept;

  assign cmd_target = DUTY_W'(clamp_duty(32'(cmd_duty), 32'(PERIOD)));

  always_comb begin
    btn_target = target;
    if (btn_inc)
      btn_target = DUTY_W'(sat_step(32'(target), 1'b1, 32'(PERIOD)));
    else if (btn_dec)
      btn_target = DUTY_W'(sat_step(32'(target), 1'b0, 32'(PERIOD)));
  end

`ifdef PWM_RAMP_CTRL_SOFT_EN
  // Divider sits at zero in IDLE so every ramp starts a fresh interval.
  pwm_step_timer #(
    .RAMP_DIV (RAMP_DIV)
  ) u_step_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (~ramp_active),
    .cnt_en      (ena),
    .period_wrap (period_wrap),
    .step        (step)
  );

  assign step_duty = DUTY_W'(step_toward(32'(duty), 32'(target)));
`else
  assign step      = ena & ramp_active & period_wrap;
  assign step_duty = target;
`endif

  assign next_duty = step ? step_duty : duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= DUTY_W'(DUTY_INIT);
      duty     <= DUTY_W'(DUTY_INIT);
      duty_upd <= 1'b0;
    end else begin
      duty_upd <= 1'b0;
      if (ena) begin
        case (state)
          IDLE: begin
            if (accept) begin
              target <= cmd_target;
              if (cmd_target != duty) state <= RAMP;
            end else if (btn_inc || btn_dec) begin
              target <= btn_target;
              if (btn_target != duty) state <= RAMP;
            end
          end
          RAMP: begin
            target <= btn_target;
            if (step) begin
              duty     <= step_duty;
              duty_upd <= 1'b1;
            end
            // Covers both the final step and a button pulling target
            // back onto the applied duty.
            if (next_duty == btn_target) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule : pwm_ramp_ctrl
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pwm_ramp_ctrl                                           |
// | Description : Self-checking bench for pwm_ramp_ctrl. Expected duty      |
// |               updates (value and the period-wrap index that causes      |
// |               them) are queued when commands are driven and compared    |
// |               when duty_upd is observed. Adapts to PWM_RAMP_CTRL_SOFT_EN.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pwm_ramp_ctrl;

  localparam int PERIOD    = 10;
  localparam int DUTY_W    = 4;
  localparam int RAMP_DIV  = 4;
  localparam int DUTY_INIT = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              period_wrap = 1'b0;
  logic              inc_pulse = 1'b0;
  logic              dec_pulse = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [DUTY_W-1:0] cmd_duty = '0;
  logic              cmd_ready;
  logic [DUTY_W-1:0] duty;
  logic              duty_upd;
  logic              busy;

  pwm_ramp_ctrl #(
    .PERIOD    (PERIOD),
    .DUTY_W    (DUTY_W),
    .RAMP_DIV  (RAMP_DIV),
    .DUTY_INIT (DUTY_INIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .period_wrap (period_wrap),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .cmd_valid   (cmd_valid),
    .cmd_duty    (cmd_duty),
    .cmd_ready   (cmd_ready),
    .duty        (duty),
    .duty_upd    (duty_upd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int wrap;
  } upd_t;

  upd_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   phase    = 0;
  int   wrap_no  = 0;
  int   upd_cnt  = 0;
  int   m_duty   = DUTY_INIT;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // PWM generator stand-in: one wrap pulse every 10 clocks.
  initial begin
    forever begin
      @(negedge clk);
      phase       = (phase == PERIOD - 1) ? 0 : phase + 1;
      period_wrap = (phase == 0);
      if (phase == 0) wrap_no++;
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && duty_upd === 1'b1) begin
      upd_t e;
      upd_cnt++;
      check_eq("upd_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("upd_duty", int'(duty), e.duty);
        check_eq("upd_wrap_index", wrap_no, e.wrap);
        check_eq("busy_at_upd", int'(busy), int'(sb_q.size() != 0));
      end
    end
  end

  task automatic plan(input int from, input int to, input int w_acc);
    upd_t e;
`ifdef PWM_RAMP_CTRL_SOFT_EN
    int d;
    int k;
    d = from;
    k = 0;
    while (d != to) begin
      d = (d < to) ? d + 1 : d - 1;
      k++;
      e.duty = d;
      e.wrap = w_acc + k * RAMP_DIV;
      sb_q.push_back(e);
    end
`else
    if (from != to) begin
      e.duty = to;
      e.wrap = w_acc + 1;
      sb_q.push_back(e);
    end
`endif
  endtask

  // Land at a point in the PWM period well away from the wrap pulse.
  task automatic sync();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while (phase != 3 && g < 30);
  endtask

  task automatic host_cmd(input int val, input bit with_inc, output int w_acc);
    int t;
    sync();
    cmd_valid = 1'b1;
    cmd_duty  = DUTY_W'(val);
    inc_pulse = with_inc;
    w_acc     = wrap_no;
    t         = (val > PERIOD) ? PERIOD : val;
    plan(m_duty, t, w_acc);
    m_duty    = t;
    @(negedge clk);
    #1;
    cmd_valid = 1'b0;
    inc_pulse = 1'b0;
    check_eq("cmd_ready_drop", int'(cmd_ready), 0);
    check_eq("busy_rise", int'(busy), 1);
  endtask

  task automatic press(input bit inc, input bit dec);
    sync();
    inc_pulse = inc;
    dec_pulse = dec;
    @(negedge clk);
    #1;
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("idle_within_budget", int'(n < maxc), 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int w;
    int u0;
    int g;

    // Reset values, cmd_ready held low during reset even with ena high.
    ena = 1'b1;
    wait_cycles(3);
    check_eq("rst_duty", int'(duty), DUTY_INIT);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_duty_upd", int'(duty_upd), 0);
    check_eq("rst_cmd_ready", int'(cmd_ready), 0);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    check_eq("ena0_cmd_ready", int'(cmd_ready), 0);
    ena = 1'b1;
    wait_cycles(1);
    check_eq("ena1_cmd_ready", int'(cmd_ready), 1);
    check_eq("post_rst_duty", int'(duty), DUTY_INIT);

    // Host 5 -> 8.
    u0 = upd_cnt;
    host_cmd(8, 1'b0, w);
    wait_idle(1000);
    check_eq("ramp8_duty", int'(duty), 8);
    check_eq("ramp8_cmd_ready", int'(cmd_ready), 1);
`ifdef PWM_RAMP_CTRL_SOFT_EN
    check_eq("ramp8_upd_count", upd_cnt - u0, 3);
`else
    check_eq("ramp8_upd_count", upd_cnt - u0, 1);
`endif

    // Clamp 15 -> 10, then saturation at both ends.
    host_cmd(15, 1'b0, w);
    wait_idle(1000);
    check_eq("clamp_duty", int'(duty), PERIOD);
    press(1'b1, 1'b0);
    check_eq("inc_sat_busy", int'(busy), 0);
    wait_cycles(5);
    check_eq("inc_sat_duty", int'(duty), PERIOD);
    host_cmd(0, 1'b0, w);
    wait_idle(2000);
    check_eq("ramp0_duty", int'(duty), 0);
    press(1'b0, 1'b1);
    check_eq("dec_sat_busy", int'(busy), 0);
    wait_cycles(5);
    check_eq("dec_sat_duty", int'(duty), 0);

    // Simultaneous +/- cancel.
    press(1'b1, 1'b1);
    check_eq("incdec_busy", int'(busy), 0);
    check_eq("incdec_duty", int'(duty), 0);

    // Host wins over a concurrent button.
    host_cmd(3, 1'b1, w);
    wait_idle(1000);
    check_eq("host_prio_duty", int'(duty), 3);

    // Back to 5, then a ramp to 8 extended by a button.
    host_cmd(5, 1'b0, w);
    wait_idle(1000);
    check_eq("back5_duty", int'(duty), 5);
    host_cmd(8, 1'b0, w);
`ifdef PWM_RAMP_CTRL_SOFT_EN
    g = 0;
    while (sb_q.size() > 2 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    check_eq("reach6_in_budget", int'(g < 200), 1);
    check_eq("at6_duty", int'(duty), 6);
    press(1'b1, 1'b0);
    begin
      upd_t e;
      e.duty = 9;
      e.wrap = w + 4 * RAMP_DIV;
      sb_q.push_back(e);
    end
`else
    inc_pulse = 1'b1;
    @(negedge clk);
    #1;
    inc_pulse = 1'b0;
    sb_q.delete();
    begin
      upd_t e;
      e.duty = 9;
      e.wrap = w + 1;
      sb_q.push_back(e);
    end
`endif
    m_duty = 9;
    wait_idle(1000);
    check_eq("extend_duty", int'(duty), 9);

    // Ramp cancelled by a button before the first step.
    host_cmd(5, 1'b0, w);
    wait_idle(1000);
    check_eq("down5_duty", int'(duty), 5);
    u0 = upd_cnt;
    host_cmd(6, 1'b0, w);
    dec_pulse = 1'b1;
    @(negedge clk);
    #1;
    dec_pulse = 1'b0;
    sb_q.delete();
    m_duty = 5;
    wait_cycles(1);
    check_eq("cancel_busy", int'(busy), 0);
    wait_cycles(60);
    check_eq("cancel_duty", int'(duty), 5);
    check_eq("cancel_no_upd", upd_cnt - u0, 0);
    check_eq("cancel_cmd_ready", int'(cmd_ready), 1);

    // ena low: no acceptance, no buttons.
    sync();
    ena       = 1'b0;
    cmd_valid = 1'b1;
    cmd_duty  = 4'd9;
    inc_pulse = 1'b1;
    #1;
    check_eq("ena0_ready_low", int'(cmd_ready), 0);
    wait_cycles(20);
    cmd_valid = 1'b0;
    inc_pulse = 1'b0;
    wait_cycles(1);
    check_eq("ena0_busy", int'(busy), 0);
    check_eq("ena0_duty", int'(duty), 5);
    ena = 1'b1;
    wait_cycles(25);
    check_eq("ena_restore_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a ramp.
    host_cmd(8, 1'b0, w);
    wait_cycles(25);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_duty", int'(duty), DUTY_INIT);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_cmd_ready", int'(cmd_ready), 0);
    sb_q.delete();
    m_duty = DUTY_INIT;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(50);
    check_eq("arst_after_duty", int'(duty), DUTY_INIT);
    check_eq("arst_after_ready", int'(cmd_ready), 1);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pwm_ramp_ctrl
`default_nettype wire
